// File: rtl/mem_ctrl.sv
// Owner of the byte-wide RAM/IO port: arbitrates instruction fetch against the
// load-store buffer, serialises each access into byte transfers and returns a done pulse.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        wrong_commit,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_enable,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_data_in,
    input  logic        lsb_is_load,
    input  logic [2:0]  lsb_funct3,
    output logic        lsb_done,
    output logic [31:0] lsb_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t      r_state, w_next_state;
    logic [31:0] r_addr, r_data, r_result, r_mem_a, r_if_data, r_lsb_data;
    logic [7:0]  r_mem_dout;
    logic [2:0]  r_cnt, r_len, r_funct3;
    logic        r_owner_lsb, r_last_lsb, r_suppress, r_if_done, r_lsb_done;

    logic        w_can_grant, w_grant_if, w_grant_lsb, w_stall, w_rd_last, w_wr_last, w_mem_wr;
    logic [2:0]  w_lsb_len;
    logic [1:0]  w_cap_idx, w_wr_idx;
    logic [31:0] w_assembled, w_extended;

    // No grant while a done pulse is out: the requester still holds its enable that cycle.
    assign w_can_grant = (r_state == IDLE) && !r_if_done && !r_lsb_done && !wrong_commit;
    assign w_grant_lsb = w_can_grant && lsb_enable && (!if_enable || !r_last_lsb);
    assign w_grant_if  = w_can_grant && if_enable && !w_grant_lsb;
    assign w_lsb_len   = (lsb_funct3[1:0] == 2'b00) ? 3'd1 :
                         (lsb_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign w_stall     = (r_addr >= IO_BASE) && io_buffer_full;
    assign w_rd_last   = (r_cnt == r_len);
    assign w_wr_last   = (r_cnt == r_len - 3'd1);
    assign w_cap_idx   = r_cnt[1:0] - 2'd1;
    assign w_wr_idx    = r_cnt[1:0] + 2'd1;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else if (rdy)
            r_state <= w_next_state;
    end

    // NOTE: defaults come first so no path leaves a variable unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_mem_wr     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_lsb && !lsb_is_load)
                    w_next_state = WRITE;
                else if (w_grant_lsb || w_grant_if)
                    w_next_state = READ;
            end
            READ: begin
                if (wrong_commit || w_rd_last)
                    w_next_state = IDLE;
            end
            WRITE: begin
                if (!w_stall) begin
                    w_mem_wr = 1'b1;
                    if (w_wr_last)
                        w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (rst || !rdy)
            w_mem_wr = 1'b0;
    end

    // Byte arriving on mem_din this cycle merged into the partial result.
    always_comb begin
        w_assembled = r_result;
        w_assembled[{w_cap_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        case (r_funct3)
            3'b000:  w_extended = {{24{w_assembled[7]}}, w_assembled[7:0]};
            3'b001:  w_extended = {{16{w_assembled[15]}}, w_assembled[15:0]};
            3'b100:  w_extended = {24'd0, w_assembled[7:0]};
            3'b101:  w_extended = {16'd0, w_assembled[15:0]};
            default: w_extended = w_assembled;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_result    <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_if_data   <= '0;
            r_lsb_data  <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_funct3    <= '0;
            r_owner_lsb <= 1'b0;
            r_last_lsb  <= 1'b0;
            r_suppress  <= 1'b0;
            r_if_done   <= 1'b0;
            r_lsb_done  <= 1'b0;
        end else if (rdy) begin
            r_if_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (wrong_commit) begin
                        r_if_data  <= '0;
                        r_lsb_data <= '0;
                        r_mem_a    <= '0;
                        r_mem_dout <= '0;
                    end else if (w_grant_if || w_grant_lsb) begin
                        r_addr      <= w_grant_lsb ? lsb_addr : if_addr;
                        r_mem_a     <= w_grant_lsb ? lsb_addr : if_addr;
                        r_cnt       <= '0;
                        r_result    <= '0;
                        r_suppress  <= 1'b0;
                        r_owner_lsb <= w_grant_lsb;
                        r_last_lsb  <= w_grant_lsb;
                        r_len       <= w_grant_lsb ? w_lsb_len : 3'd4;
                        r_funct3    <= w_grant_lsb ? lsb_funct3 : 3'b010;
                        r_data      <= lsb_data_in;
                        r_mem_dout  <= (w_grant_lsb && !lsb_is_load) ? lsb_data_in[7:0] : 8'd0;
                    end
                end
                READ: begin
                    if (wrong_commit) begin
                        r_if_data  <= '0;
                        r_lsb_data <= '0;
                        r_mem_a    <= '0;
                    end else if (w_rd_last) begin
                        r_mem_a <= '0;
                        if (r_owner_lsb) begin
                            r_lsb_done <= 1'b1;
                            r_lsb_data <= w_extended;
                        end else begin
                            r_if_done <= 1'b1;
                            r_if_data <= w_assembled;
                        end
                    end else begin
                        // Address runs one cycle ahead of capture; cnt==0 has no data yet.
                        if (r_cnt != 3'd0)
                            r_result <= w_assembled;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt + 3'd1 < r_len)
                            r_mem_a <= r_mem_a + 32'd1;
                    end
                end
                WRITE: begin
                    if (wrong_commit)
                        r_suppress <= 1'b1;
                    if (!w_stall) begin
                        if (w_wr_last) begin
                            r_lsb_done <= !(r_suppress || wrong_commit);
                            r_lsb_data <= '0;
                            r_mem_a    <= '0;
                            r_mem_dout <= '0;
                        end else begin
                            r_cnt      <= r_cnt + 3'd1;
                            r_mem_a    <= r_mem_a + 32'd1;
                            r_mem_dout <= r_data[{w_wr_idx, 3'b000} +: 8];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_done  = r_if_done;
    assign if_data  = r_if_data;
    assign lsb_done = r_lsb_done;
    assign lsb_data = r_lsb_data;
    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign mem_wr   = w_mem_wr;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized checks of mem_ctrl against a byte-level memory model
// and a reference model of the access rules.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, wrong_commit;
    logic        if_enable, if_done, lsb_enable, lsb_is_load, lsb_done;
    logic [31:0] if_addr, if_data, lsb_addr, lsb_data_in, lsb_data, mem_a;
    logic [2:0]  lsb_funct3;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_wr, io_buffer_full;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .wrong_commit(wrong_commit),
        .if_enable(if_enable), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_enable(lsb_enable), .lsb_addr(lsb_addr), .lsb_data_in(lsb_data_in),
        .lsb_is_load(lsb_is_load), .lsb_funct3(lsb_funct3), .lsb_done(lsb_done),
        .lsb_data(lsb_data), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // Environment RAM (what the DUT really writes) and the reference image (what it should hold).
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr)
                ram[mem_a] = mem_dout;
            mem_din <= ram.exists(mem_a) ? ram[mem_a] : init_byte(mem_a);
        end
    end

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic int ref_len(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        w = {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
        case (f3)
            3'b000:  return int'($signed(w[7:0]));
            3'b001:  return int'($signed(w[15:0]));
            3'b100:  return int'(w[7:0]);
            3'b101:  return int'(w[15:0]);
            default: return w;
        endcase
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]     = b;
        ref_mem[a] = b;
    endtask

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        for (int i = 0; i < ref_len(f3); i++)
            ref_mem[a + i] = wd[8*i +: 8];
    endtask

    int          n_vec = 0, n_err = 0;
    int          done_at, n_wr;
    logic        done_is_if;
    logic [31:0] rdata;
    logic [31:0] cyc_a [0:47];
    logic [31:0] wr_a  [0:7];
    logic [7:0]  wr_d  [0:7];
    int          wr_c  [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request at cycle 0 (called just after a posedge) and logs the port until done.
    task automatic run(input bit is_if, input logic [31:0] addr, input bit is_load,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input logic [15:0] stall, input logic [15:0] hold, input int flush_at);
        done_at = -1; n_wr = 0; rdata = '0; done_is_if = 1'b0;
        for (int i = 0; i < 48; i++) cyc_a[i] = 'x;
        for (int i = 0; i < 8; i++) begin wr_a[i] = 'x; wr_d[i] = 'x; wr_c[i] = -1; end
        if_enable = is_if; if_addr = addr;
        lsb_enable = !is_if; lsb_addr = addr; lsb_is_load = is_load;
        lsb_funct3 = f3; lsb_data_in = wd;
        io_buffer_full = stall[0]; rdy = !hold[0]; wrong_commit = (flush_at == 0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cyc_a[c] = mem_a;
            if (mem_wr && n_wr < 8) begin
                wr_a[n_wr] = mem_a; wr_d[n_wr] = mem_dout; wr_c[n_wr] = c; n_wr++;
            end
            if ((if_done || lsb_done) && done_at < 0) begin
                done_at = c; done_is_if = if_done; rdata = if_done ? if_data : lsb_data;
            end
            @(posedge clk); #1;
            wrong_commit = (c + 1 == flush_at);
            if ((flush_at >= 0 && c + 1 >= flush_at) || done_at >= 0) begin
                if_enable = 1'b0; lsb_enable = 1'b0;
            end
            io_buffer_full = (c + 1 < 16) ? stall[c + 1] : 1'b0;
            rdy            = (c + 1 < 16) ? !hold[c + 1] : 1'b1;
            if (done_at >= 0 || (flush_at >= 0 && c >= flush_at + 6)) break;
        end
        wrong_commit = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
        if_enable = 1'b0; lsb_enable = 1'b0;
    endtask

    int          ev_c  [0:3];
    logic        ev_if [0:3];
    int          n_ev, kind, len, c, wr_cnt;
    logic [31:0] a, wd, exp_data, exp_w;
    logic [2:0]  f3;
    logic [15:0] stl;
    bit          io;
    logic [2:0]  load_f3 [0:4];

    initial begin
        load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1'b1; rdy = 1'b1; wrong_commit = 1'b0; io_buffer_full = 1'b0;
        if_enable = 1'b0; if_addr = '0; lsb_enable = 1'b0; lsb_addr = '0;
        lsb_data_in = '0; lsb_is_load = 1'b0; lsb_funct3 = '0;
        preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
        preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
        preload(32'h20, 8'h80);
        preload(32'h40, 8'h34); preload(32'h41, 8'hF2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_if_done", if_done, 0);   check("rst_if_data", if_data, 0);
        check("rst_lsb_done", lsb_done, 0); check("rst_lsb_data", lsb_data, 0);
        check("rst_mem_a", mem_a, 0);       check("rst_mem_dout", mem_dout, 0);
        check("rst_mem_wr", mem_wr, 0);
        @(posedge clk); #1;

        run(1, 32'h1000, 1, 3'b010, 0, 0, 0, -1);
        check("fetch_cycle", done_at, 6);  check("fetch_owner", done_is_if, 1);
        check("fetch_data", rdata, 32'h0000_0513);
        check("fetch_a0", cyc_a[0], 0);    check("fetch_a1", cyc_a[1], 32'h1000);
        check("fetch_a4", cyc_a[4], 32'h1003);

        run(0, 32'h20, 1, 3'b000, 0, 0, 0, -1);
        check("lb_cycle", done_at, 3); check("lb_data", rdata, 32'hFFFF_FF80);
        run(0, 32'h20, 1, 3'b100, 0, 0, 0, -1);
        check("lbu_cycle", done_at, 3); check("lbu_data", rdata, 32'h0000_0080);
        run(0, 32'h40, 1, 3'b001, 0, 0, 0, -1);
        check("lh_cycle", done_at, 4); check("lh_data", rdata, 32'hFFFF_F234);

        exp_w = 32'hDEAD_BEEF;
        run(0, 32'h100, 0, 3'b010, exp_w, 0, 0, -1);
        model_store(32'h100, 3'b010, exp_w);
        check("sw_nwr", n_wr, 4);
        for (int i = 0; i < 4; i++) begin
            check("sw_wr_cycle", wr_c[i], i + 1);
            check("sw_wr_addr", wr_a[i], 32'h100 + i);
            check("sw_wr_byte", wr_d[i], exp_w[8*i +: 8]);
        end
        check("sw_cycle", done_at, 5); check("sw_data", rdata, 0);

        run(0, 32'h3_0000, 0, 3'b000, 32'h41, 16'b1110, 0, -1);
        check("io_sb_nwr", n_wr, 1);        check("io_sb_wr_cycle", wr_c[0], 4);
        check("io_sb_addr", wr_a[0], 32'h3_0000); check("io_sb_byte", wr_d[0], 8'h41);
        check("io_sb_cycle", done_at, 5);

        run(0, 32'h100, 1, 3'b010, 0, 0, 0, 3);
        check("lw_flush_nodone", done_at, -1);
        check("lw_flush_a3", cyc_a[3], 32'h102); check("lw_flush_a4", cyc_a[4], 0);

        run(0, 32'h104, 0, 3'b010, 32'hCAFE_F00D, 0, 0, 2);
        model_store(32'h104, 3'b010, 32'hCAFE_F00D);
        check("sw_flush_nodone", done_at, -1); check("sw_flush_nwr", n_wr, 4);
        check("sw_flush_last_cycle", wr_c[3], 4); check("sw_flush_last_byte", wr_d[3], 8'hCA);
        run(0, 32'h104, 1, 3'b010, 0, 0, 0, -1);
        check("lw_after_flush_cycle", done_at, 6); check("lw_after_flush_data", rdata, 32'hCAFE_F00D);

        run(0, 32'h100, 1, 3'b010, 0, 0, 16'b1100, -1);
        check("rdy_hold_cycle", done_at, 8); check("rdy_hold_data", rdata, 32'hDEAD_BEEF);

        // Both requesters from reset, both re-requesting continuously.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin ev_c[i] = -1; ev_if[i] = 1'bx; end
        n_ev = 0;
        if_enable = 1'b1; if_addr = 32'h1000;
        lsb_enable = 1'b1; lsb_addr = 32'h20; lsb_is_load = 1'b1; lsb_funct3 = 3'b000;
        for (int cc = 0; cc < 40 && n_ev < 4; cc++) begin
            @(negedge clk);
            if (lsb_done && n_ev < 4) begin ev_c[n_ev] = cc; ev_if[n_ev] = 1'b0; n_ev++; end
            if (if_done && n_ev < 4)  begin ev_c[n_ev] = cc; ev_if[n_ev] = 1'b1; n_ev++; end
            @(posedge clk); #1;
        end
        if_enable = 1'b0; lsb_enable = 1'b0;
        check("arb0_if", ev_if[0], 0); check("arb0_cycle", ev_c[0], 3);
        check("arb1_if", ev_if[1], 1); check("arb1_cycle", ev_c[1], 10);
        check("arb2_if", ev_if[2], 0); check("arb2_cycle", ev_c[2], 14);
        check("arb3_if", ev_if[3], 1); check("arb3_cycle", ev_c[3], 21);
        repeat (8) @(posedge clk);
        #1;

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                a = 32'h200 + $urandom_range(0, 60);
                exp_data = ref_load(a, 3'b010);
                run(1, a, 1, 3'b010, 0, 0, 0, -1);
                check("rnd_fetch_cycle", done_at, 6); check("rnd_fetch_owner", done_is_if, 1);
                check("rnd_fetch_data", rdata, exp_data);
            end else if (kind == 1) begin
                f3 = load_f3[$urandom_range(0, 4)];
                a = 32'h200 + $urandom_range(0, 60);
                exp_data = ref_load(a, f3);
                len = ref_len(f3);
                run(0, a, 1, f3, 0, 0, 0, -1);
                check("rnd_load_cycle", done_at, len + 2); check("rnd_load_data", rdata, exp_data);
            end else begin
                f3 = 3'($urandom_range(0, 2));
                io = ($urandom_range(0, 3) == 0);
                a = io ? 32'h3_0000 + $urandom_range(0, 12) : 32'h200 + $urandom_range(0, 60);
                wd = $urandom;
                stl = io ? 16'($urandom & $urandom) : 16'h0;
                len = ref_len(f3);
                // Each byte needs one cycle without IO back-pressure, starting at cycle 1.
                c = 1; wr_cnt = 0;
                while (wr_cnt < len) begin
                    if (!(io && c < 16 && stl[c])) wr_cnt++;
                    c++;
                end
                run(0, a, 0, f3, wd, stl, 0, -1);
                model_store(a, f3, wd);
                check("rnd_store_cycle", done_at, c); check("rnd_store_nwr", n_wr, len);
                check("rnd_store_data", rdata, 0);
                check("rnd_store_first_addr", wr_a[0], a);
                check("rnd_store_first_byte", wr_d[0], wd[7:0]);
                check("rnd_store_last_addr", wr_a[len - 1], a + len - 1);
                check("rnd_store_last_byte", wr_d[len - 1], wd[8*(len - 1) +: 8]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that owns the single byte-wide RAM/IO port and shares it between the instruction-fetch unit and the load-store buffer. Each requester presents a word-aligned or sub-word access. The block serialises the access into byte transfers, assembles or sign/zero-extends read data, and returns a one-cycle done pulse. It sits between the CPU core (fetch unit, load-store buffer, ROB flush line) and the top-level RAM/IO bus.

## Interface
- IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO space; subject to write back-pressure
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low all state freezes
- wrong_commit  in  1  ROB flush (mispredict)
- if_enable  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address (word)
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction, little-endian
- lsb_enable  in  1  LSB request, level, held until lsb_done
- lsb_addr  in  32  byte address
- lsb_data_in  in  32  store data (low bytes used)
- lsb_is_load  in  1  1 = load, 0 = store
- lsb_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- lsb_done  out  1  one-cycle pulse
- lsb_data  out  32  extended load result; 0 for stores
- mem_din  in  8  RAM read byte, valid one cycle after mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO write FIFO full

## Operation
- States: IDLE, READ, WRITE. Byte counter cnt (0..3), length len (1/2/4 from funct3[1:0]; fetch always 4), owner flag (IF/LSB), last_owner flag.
- Reset/flush outputs: if_done=0, if_data=0, lsb_done=0, lsb_data=0, mem_a=0, mem_dout=0, mem_wr=0, state IDLE, last_owner=IF.
- IDLE arbitration: only one requester → grant it. Both → grant the one that is not last_owner (round-robin). Latch addr, len, funct3, data, owner. Load/fetch → READ. Store → WRITE.
- READ: byte k is addressed at A+k and captured into result[8k+7:8k] one cycle later. After the last capture, pulse the owner's done with the assembled data.
- LSB result extension: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW is passed through.
- WRITE: each cycle drive mem_a=A+k, mem_dout=data[8k+7:8k], mem_wr=1. After byte len-1, pulse lsb_done with lsb_data=0.
- IO back-pressure: if A >= IO_BASE and io_buffer_full=1, hold mem_wr=0 and do not advance cnt. Resume the same byte when io_buffer_full drops.
- mem_wr is 0 in every cycle not actively writing a byte, including IDLE and READ.
- done pulses last exactly one cycle. The controller returns to IDLE in the same cycle done is asserted and may start a new grant the following cycle. Requesters must not re-sample done.
- wrong_commit: READ (fetch or load) aborts immediately; next cycle state is IDLE, no done pulse. WRITE continues until all bytes are written, because the store is already committed. Its lsb_done is suppressed. New grants are blocked until WRITE ends.
- rdy=0: no register changes; mem_wr forced 0.
- Address arithmetic is 32-bit wrap-around; no alignment checks.

## Timing
- Cycle 0 is the IDLE cycle in which a request is sampled and granted.
- Read of N bytes: mem_a=A+k at cycle k+1 (k=0..N-1). mem_din captured at cycle k+2. done asserted at cycle N+2. Word fetch/LW therefore returns at cycle 6, LB at cycle 3.
- Write of N bytes, no stall: mem_wr=1 at cycles 1..N; lsb_done at cycle N+1. Each IO stall cycle adds one cycle.
- Back-to-back accesses: the earliest next grant is cycle done+1. The port is never idle more than one cycle between pending requests.
- Flush at cycle t during READ: state is IDLE at t+1. Any mem_din arriving after t is ignored.

## Test plan
- Reset, then fetch at 0x0000_1000 with RAM bytes 13 05 00 00 -> if_done at cycle 6, if_data=0x0000_0513; other outputs at reset values before.
- LB at 0x20 holding 0x80 -> lsb_data=0xFFFF_FF80 at cycle 3. LBU at the same address -> lsb_data=0x0000_0080. LH on bytes 34 F2 -> lsb_data=0xFFFF_F234.
- if_enable and lsb_enable raised together from reset -> LSB granted first (last_owner=IF), fetch granted the cycle after lsb_done. Both held continuously -> grants alternate.
- SW 0xDEADBEEF to 0x100 -> mem_wr=1 cycles 1..4 with mem_dout EF BE AD DE at 0x100..0x103, lsb_done at cycle 5, lsb_data=0.
- SB 0x41 to 0x30000 with io_buffer_full high for cycles 1-3 -> mem_wr=0 during the stall, single write at cycle 4, lsb_done at cycle 5.
- wrong_commit at cycle 3 of LW -> no lsb_done, IDLE at cycle 4. wrong_commit during SW byte 1 -> remaining bytes still written, lsb_done suppressed.
